cmd_cfg_mc: RTL and testbench
=============================

# cmd_cfg_mc

Parametrised command/configuration block for the logic-analyzer core. It decodes 16-bit host commands from the UART wrapper and holds the trigger/capture register set for `NUM_CH` channels. It returns one-byte responses and streams a full circular capture buffer for any selected channel to the host. It sits between the UART command receiver and the capture controller/channel RAMs.

## Interface
Parameters:
- `NUM_CH`, 5, number of capture channels (1..15)
- `ENTRIES`, 384, capture RAM depth per channel
- `LOG2`, 9, RAM address width; must satisfy 2^LOG2 >= ENTRIES

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `cmd` in 16: host command; `[15:14]` opcode, `[13:8]` address/channel, `[7:0]` data.
- `cmd_rdy` in 1: `cmd` valid; held until `clr_cmd_rdy`.
- `resp_sent` in 1: one-cycle pulse, UART finished sending `resp`.
- `set_capture_done` in 1: pulse from capture controller.
- `waddr` in LOG2: last RAM address written by capture.
- `rdata` in NUM_CH*8: packed RAM read data; channel k occupies `[8k-1:8k-8]`.
- `raddr` out LOG2: shared RAM read address.
- `TrigCfg` out 6; `ChTrigCfg` out NUM_CH*5, packed per channel.
- `decimator` out 4.
- `VIH`, `VIL`, `matchH`, `matchL`, `maskH`, `maskL`, `baud_cntH`, `baud_cntL`, `trig_posH`, `trig_posL` out 8 each.
- `resp` out 8: response byte.
- `send_resp` out 1: one-cycle start pulse to the UART.
- `clr_cmd_rdy` out 1: one-cycle pulse ending the current command.

## Operation
- Register map:
  - 0x00: TrigCfg.
  - 0x01..NUM_CH: ChTrigCfg for channel 1..NUM_CH.
  - 0x10: decimator.
  - 0x11: VIH. 0x12: VIL.
  - 0x13: matchH. 0x14: matchL.
  - 0x15: maskH. 0x16: maskL.
  - 0x17: baud_cntH. 0x18: baud_cntL.
  - 0x19: trig_posH. 0x1A: trig_posL.
  - Any other address is unmapped.
- Reset values: TrigCfg 0x03; every ChTrigCfg 0x01; decimator 0; VIH 0xAA; VIL 0x55; match/mask 0x00; baud_cntH 0x06; baud_cntL 0xC8; trig_posH 0x00; trig_posL 0x01. `resp`, `raddr`, `send_resp`, `clr_cmd_rdy` reset to 0.
- Opcode 00, read: `resp` = register value, zero-extended. Unmapped address → 0xEE.
- Opcode 01, write: the register takes `cmd[W-1:0]` and `resp` = 0xA5. Unmapped address → no write, `resp` = 0xEE.
- Opcode 10, dump. Channel = `cmd[11:8]`.
  - Channel 0 or channel > NUM_CH → 0xEE.
  - TrigCfg[5] == 0 (capture not done) → 0xEE.
  - Otherwise send ENTRIES bytes, oldest first. Start at `raddr` = waddr+1, wrapping from ENTRIES-1 to 0, and end at `waddr`.
- Opcode 11: reserved → 0xEE.
- `set_capture_done` sets TrigCfg[5]. If it coincides with a write to 0x00, the written data is stored with bit 5 forced to 1.
- State machine:
  - IDLE → RESP_WAIT on a read, write, or NAK.
  - IDLE → DMP_RD on a valid dump.
  - RESP_WAIT → IDLE on `resp_sent`, pulsing `clr_cmd_rdy`.
  - DMP_RD → DMP_SEND: one cycle of RAM read latency.
  - DMP_SEND → DMP_WAIT: `resp` = selected channel byte, pulse `send_resp`.
  - DMP_WAIT, on `resp_sent`:
    - Byte counter == ENTRIES-1 → IDLE, pulsing `clr_cmd_rdy`.
    - Otherwise increment the counter (LOG2+1 bits), advance `raddr` with wrap, → DMP_RD.
- `cmd_rdy` is ignored outside IDLE. `cmd` is stable while `cmd_rdy` is high.

## Timing
- `cmd_rdy` sampled in IDLE at cycle N:
  - Register write visible at N+1.
  - `resp` and `send_resp` registered, valid together at N+1.
- `resp_sent` at cycle M → `clr_cmd_rdy` high at M+1 for one cycle. Ready for a new command at M+2.
- Dump timing:
  - `raddr` valid at N+1; `rdata` sampled at N+2; first `send_resp` at N+3.
  - Each later byte: `resp_sent` at M → `raddr` update at M+1 → `send_resp` at M+3.
- Exactly one `send_resp` per byte. Never two without an intervening `resp_sent`.
- `rst` mid-operation: next cycle returns to IDLE and all registers to reset values. No `clr_cmd_rdy` is issued.

## Structure
- Package `la_cfg_pkg`:
  - opcode enum.
  - state enum.
  - register address localparams.
  - ACK 0xA5 / NAK 0xEE constants.
  - Reset-value constants.
- One sub-module, `cfg_regfile`: register storage, write decode, read mux, unmapped flag, capture-done merge.
- FSM, dump counter, address wrap and channel select live in the top module.

## Test plan
- After reset, read 0x17, then 0x18 → responses 0x06, 0xC8; each `clr_cmd_rdy` one cycle after `resp_sent`.
- Write 0x11 ← 0x80, then read 0x11 → 0xA5, then 0x80. Write 0x1F → 0xEE and no register changes.
- Write 0x00 ← 0x01 in the same cycle as `set_capture_done` → TrigCfg = 0x21.
- With NUM_CH = 5, ENTRIES = 384, TrigCfg[5] = 1, waddr = 383, dump channel 3 → 384 bytes from `raddr` 0..383, each equal to the channel-3 RAM content.
- With waddr = 10 → first `raddr` 11, wrap 383 → 0, last `raddr` 10, exactly 384 `send_resp` pulses. Dump channel 6 → 0xEE.
- Assert `rst` after the 100th dump byte → outputs at reset values next cycle; a subsequent read of 0x00 returns 0x03.

Source files
------------

// File: rtl/la_cfg_pkg.sv
// Shared types and constants for the logic-analyzer command/configuration block.
package la_cfg_pkg;

  typedef enum logic [1:0] {
    OP_RD  = 2'b00,
    OP_WR  = 2'b01,
    OP_DMP = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESP_WAIT = 3'd1,
    S_DMP_RD    = 3'd2,
    S_DMP_SEND  = 3'd3,
    S_DMP_WAIT  = 3'd4
  } state_t;

  localparam logic [5:0] ADDR_TRIG    = 6'h00;
  localparam logic [5:0] ADDR_DEC     = 6'h10;
  localparam logic [5:0] ADDR_VIH     = 6'h11;
  localparam logic [5:0] ADDR_VIL     = 6'h12;
  localparam logic [5:0] ADDR_MATCH_H = 6'h13;
  localparam logic [5:0] ADDR_MATCH_L = 6'h14;
  localparam logic [5:0] ADDR_MASK_H  = 6'h15;
  localparam logic [5:0] ADDR_MASK_L  = 6'h16;
  localparam logic [5:0] ADDR_BAUD_H  = 6'h17;
  localparam logic [5:0] ADDR_BAUD_L  = 6'h18;
  localparam logic [5:0] ADDR_TPOS_H  = 6'h19;
  localparam logic [5:0] ADDR_TPOS_L  = 6'h1A;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  localparam logic [5:0] RST_TRIG   = 6'h03;
  localparam logic [4:0] RST_CH     = 5'h01;
  localparam logic [3:0] RST_DEC    = 4'h0;
  localparam logic [7:0] RST_VIH    = 8'hAA;
  localparam logic [7:0] RST_VIL    = 8'h55;
  localparam logic [7:0] RST_MATCH  = 8'h00;
  localparam logic [7:0] RST_MASK   = 8'h00;
  localparam logic [7:0] RST_BAUD_H = 8'h06;
  localparam logic [7:0] RST_BAUD_L = 8'hC8;
  localparam logic [7:0] RST_TPOS_H = 8'h00;
  localparam logic [7:0] RST_TPOS_L = 8'h01;

endpackage

// File: rtl/cmd_cfg_mc_if.sv
// Host-side command/response handshake between the UART wrapper and the config block.
interface cmd_cfg_mc_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;

  modport master (
    output cmd, cmd_rdy, resp_sent,
    input  clr_cmd_rdy, resp, send_resp
  );

  modport slave (
    input  cmd, cmd_rdy, resp_sent,
    output clr_cmd_rdy, resp, send_resp
  );
endinterface

// File: rtl/cfg_regfile.sv
// Trigger/capture register set: storage, write decode, read mux and capture-done merge.
module cfg_regfile
  import la_cfg_pkg::*;
#(
  parameter int NUM_CH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [5:0]            addr,
  input  logic [7:0]            wdata,
  input  logic                  set_capture_done,
  output logic [7:0]            rd_data,
  output logic                  unmapped,
  output logic [5:0]            trig_cfg,
  output logic [NUM_CH*5-1:0]   ch_trig_cfg,
  output logic [3:0]            decimator,
  output logic [7:0]            vih,
  output logic [7:0]            vil,
  output logic [7:0]            match_h,
  output logic [7:0]            match_l,
  output logic [7:0]            mask_h,
  output logic [7:0]            mask_l,
  output logic [7:0]            baud_cnt_h,
  output logic [7:0]            baud_cnt_l,
  output logic [7:0]            trig_pos_h,
  output logic [7:0]            trig_pos_l
);

  // Read mux with zero extension; channel registers occupy 0x01..NUM_CH.
  always_comb begin
    unmapped = 1'b0;
    rd_data  = '0;
    case (addr)
      ADDR_TRIG:    rd_data = {2'b00, trig_cfg};
      ADDR_DEC:     rd_data = {4'h0, decimator};
      ADDR_VIH:     rd_data = vih;
      ADDR_VIL:     rd_data = vil;
      ADDR_MATCH_H: rd_data = match_h;
      ADDR_MATCH_L: rd_data = match_l;
      ADDR_MASK_H:  rd_data = mask_h;
      ADDR_MASK_L:  rd_data = mask_l;
      ADDR_BAUD_H:  rd_data = baud_cnt_h;
      ADDR_BAUD_L:  rd_data = baud_cnt_l;
      ADDR_TPOS_H:  rd_data = trig_pos_h;
      ADDR_TPOS_L:  rd_data = trig_pos_l;
      default: begin
        unmapped = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
          if (addr == 6'(k + 1)) begin
            unmapped = 1'b0;
            rd_data  = {3'b000, ch_trig_cfg[k*5 +: 5]};
          end
        end
      end
    endcase
  end

  // Register storage; capture-done forces TrigCfg[5] even over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_cfg    <= RST_TRIG;
      ch_trig_cfg <= {NUM_CH{RST_CH}};
      decimator   <= RST_DEC;
      vih         <= RST_VIH;
      vil         <= RST_VIL;
      match_h     <= RST_MATCH;
      match_l     <= RST_MATCH;
      mask_h      <= RST_MASK;
      mask_l      <= RST_MASK;
      baud_cnt_h  <= RST_BAUD_H;
      baud_cnt_l  <= RST_BAUD_L;
      trig_pos_h  <= RST_TPOS_H;
      trig_pos_l  <= RST_TPOS_L;
    end else begin
      if (we && addr == ADDR_TRIG)
        trig_cfg <= wdata[5:0] | {set_capture_done, 5'b00000};
      else if (set_capture_done)
        trig_cfg[5] <= 1'b1;
      for (int k = 0; k < NUM_CH; k++) begin
        if (we && addr == 6'(k + 1))
          ch_trig_cfg[k*5 +: 5] <= wdata[4:0];
      end
      if (we) begin
        case (addr)
          ADDR_DEC:     decimator  <= wdata[3:0];
          ADDR_VIH:     vih        <= wdata;
          ADDR_VIL:     vil        <= wdata;
          ADDR_MATCH_H: match_h    <= wdata;
          ADDR_MATCH_L: match_l    <= wdata;
          ADDR_MASK_H:  mask_h     <= wdata;
          ADDR_MASK_L:  mask_l     <= wdata;
          ADDR_BAUD_H:  baud_cnt_h <= wdata;
          ADDR_BAUD_L:  baud_cnt_l <= wdata;
          ADDR_TPOS_H:  trig_pos_h <= wdata;
          ADDR_TPOS_L:  trig_pos_l <= wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/cmd_cfg_mc.sv
// Host command decoder: register read/write responses and circular capture-buffer dump.
module cmd_cfg_mc
  import la_cfg_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic                clk,
  input  logic                rst,
  cmd_cfg_mc_if.slave         host,
  input  logic                set_capture_done,
  input  logic [LOG2-1:0]     waddr,
  input  logic [NUM_CH*8-1:0] rdata,
  output logic [LOG2-1:0]     raddr,
  output logic [5:0]          TrigCfg,
  output logic [NUM_CH*5-1:0] ChTrigCfg,
  output logic [3:0]          decimator,
  output logic [7:0]          VIH,
  output logic [7:0]          VIL,
  output logic [7:0]          matchH,
  output logic [7:0]          matchL,
  output logic [7:0]          maskH,
  output logic [7:0]          maskL,
  output logic [7:0]          baud_cntH,
  output logic [7:0]          baud_cntL,
  output logic [7:0]          trig_posH,
  output logic [7:0]          trig_posL
);

  state_t        state, state_nxt;
  op_t           op;
  logic [5:0]    addr;
  logic [3:0]    ch;
  logic [7:0]    rd_data;
  logic          unmapped;
  logic          accept;
  logic          dump_ok;
  logic          reg_we;
  logic          last_byte;
  logic [7:0]    ch_byte;

  logic [7:0]    resp_q, resp_nxt;
  logic          send_q, send_nxt;
  logic          clr_q, clr_nxt;
  logic [LOG2-1:0] raddr_nxt;
  logic [LOG2:0] cnt, cnt_nxt;
  logic [3:0]    dmp_ch, dmp_ch_nxt;

  // Circular RAM address increment, wrapping at the configured depth.
  function automatic logic [LOG2-1:0] next_addr(input logic [LOG2-1:0] a);
    return (32'(a) == ENTRIES - 1) ? '0 : a + 1'b1;
  endfunction

  assign op   = op_t'(host.cmd[15:14]);
  assign addr = host.cmd[13:8];
  assign ch   = host.cmd[11:8];

  // A command is taken only in IDLE and never in the cycle its predecessor is being cleared.
  assign accept    = (state == S_IDLE) && host.cmd_rdy && !clr_q;
  assign dump_ok   = (ch != 4'd0) && (32'(ch) <= NUM_CH) && TrigCfg[5];
  assign reg_we    = accept && (op == OP_WR) && !unmapped;
  assign last_byte = (32'(cnt) == ENTRIES - 1);

  assign host.resp        = resp_q;
  assign host.send_resp   = send_q;
  assign host.clr_cmd_rdy = clr_q;

  cfg_regfile #(.NUM_CH(NUM_CH)) u_regfile (
    .clk              (clk),
    .rst              (rst),
    .we               (reg_we),
    .addr             (addr),
    .wdata            (host.cmd[7:0]),
    .set_capture_done (set_capture_done),
    .rd_data          (rd_data),
    .unmapped         (unmapped),
    .trig_cfg         (TrigCfg),
    .ch_trig_cfg      (ChTrigCfg),
    .decimator        (decimator),
    .vih              (VIH),
    .vil              (VIL),
    .match_h          (matchH),
    .match_l          (matchL),
    .mask_h           (maskH),
    .mask_l           (maskL),
    .baud_cnt_h       (baud_cntH),
    .baud_cnt_l       (baud_cntL),
    .trig_pos_h       (trig_posH),
    .trig_pos_l       (trig_posL)
  );

  // Byte lane of the channel being dumped.
  always_comb begin
    ch_byte = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (32'(dmp_ch) == k + 1)
        ch_byte = rdata[k*8 +: 8];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (accept) state_nxt = (op == OP_DMP && dump_ok) ? S_DMP_RD : S_RESP_WAIT;
      S_RESP_WAIT: if (host.resp_sent) state_nxt = S_IDLE;
      S_DMP_RD:    state_nxt = S_DMP_SEND;
      S_DMP_SEND:  state_nxt = S_DMP_WAIT;
      S_DMP_WAIT:  if (host.resp_sent) state_nxt = last_byte ? S_IDLE : S_DMP_RD;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered response, handshake and dump pointers.
  always_comb begin
    resp_nxt   = resp_q;
    send_nxt   = 1'b0;
    clr_nxt    = 1'b0;
    raddr_nxt  = raddr;
    cnt_nxt    = cnt;
    dmp_ch_nxt = dmp_ch;
    case (state)
      S_IDLE: begin
        if (accept) begin
          send_nxt = 1'b1;
          case (op)
            OP_RD: resp_nxt = unmapped ? NAK : rd_data;
            OP_WR: resp_nxt = unmapped ? NAK : ACK;
            OP_DMP: begin
              if (dump_ok) begin
                send_nxt   = 1'b0;
                raddr_nxt  = next_addr(waddr);
                cnt_nxt    = '0;
                dmp_ch_nxt = ch;
              end else begin
                resp_nxt = NAK;
              end
            end
            default: resp_nxt = NAK;
          endcase
        end
      end
      S_RESP_WAIT: clr_nxt = host.resp_sent;
      S_DMP_SEND: begin
        resp_nxt = ch_byte;
        send_nxt = 1'b1;
      end
      S_DMP_WAIT: begin
        if (host.resp_sent) begin
          if (last_byte) begin
            clr_nxt = 1'b1;
          end else begin
            cnt_nxt   = cnt + 1'b1;
            raddr_nxt = next_addr(raddr);
          end
        end
      end
      default: ;
    endcase
  end

  // Output and dump-pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= '0;
      send_q <= 1'b0;
      clr_q  <= 1'b0;
      raddr  <= '0;
      cnt    <= '0;
      dmp_ch <= '0;
    end else begin
      resp_q <= resp_nxt;
      send_q <= send_nxt;
      clr_q  <= clr_nxt;
      raddr  <= raddr_nxt;
      cnt    <= cnt_nxt;
      dmp_ch <= dmp_ch_nxt;
    end
  end

endmodule

// File: tb/tb_cmd_cfg_mc.sv
// Directed bench for cmd_cfg_mc with a response scoreboard and a synchronous RAM model.
module tb_cmd_cfg_mc;
  import la_cfg_pkg::*;

  localparam int NUM_CH  = 5;
  localparam int ENTRIES = 384;
  localparam int LOG2    = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_cfg_mc_if host();

  logic                set_capture_done;
  logic [LOG2-1:0]     waddr;
  logic [NUM_CH*8-1:0] rdata = '0;
  logic [LOG2-1:0]     raddr;
  logic [5:0]          TrigCfg;
  logic [NUM_CH*5-1:0] ChTrigCfg;
  logic [3:0]          decimator;
  logic [7:0]          VIH, VIL, matchH, matchL, maskH, maskL;
  logic [7:0]          baud_cntH, baud_cntL, trig_posH, trig_posL;

  cmd_cfg_mc #(.NUM_CH(NUM_CH), .ENTRIES(ENTRIES), .LOG2(LOG2)) dut (
    .clk(clk), .rst(rst), .host(host),
    .set_capture_done(set_capture_done), .waddr(waddr), .rdata(rdata), .raddr(raddr),
    .TrigCfg(TrigCfg), .ChTrigCfg(ChTrigCfg), .decimator(decimator),
    .VIH(VIH), .VIL(VIL), .matchH(matchH), .matchL(matchL), .maskH(maskH), .maskL(maskL),
    .baud_cntH(baud_cntH), .baud_cntL(baud_cntL), .trig_posH(trig_posH), .trig_posL(trig_posL)
  );

  typedef struct {
    logic [7:0] b;
    int         a;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_send = 0;
  int   last_rs_cyc = -100;

  function automatic logic [7:0] ram_byte(input int ch, input int a);
    return 8'((a * 13 + ch * 57 + (a >> 3)) & 255);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous channel RAMs: one cycle read latency.
  always @(posedge clk)
    for (int k = 0; k < NUM_CH; k++) rdata[k*8 +: 8] <= ram_byte(k + 1, int'(raddr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s got=0x%0h want=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic push(input logic [7:0] b, input int a);
    exp_t e;
    e.b = b;
    e.a = a;
    exp_q.push_back(e);
  endtask

  // UART model: acknowledge each send_resp one cycle later with a one-cycle resp_sent.
  initial begin
    host.resp_sent = 1'b0;
    forever begin
      @(negedge clk);
      if (host.send_resp && !rst) begin
        @(posedge clk);
        #1 host.resp_sent = 1'b1;
        last_rs_cyc = cyc;
        @(posedge clk);
        #1 host.resp_sent = 1'b0;
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    logic outstanding;
    exp_t e;
    outstanding = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        outstanding = 1'b0;
      end else begin
        if (host.resp_sent) outstanding = 1'b0;
        if (host.send_resp) begin
          n_send++;
          check("one_send_per_byte", {31'b0, outstanding}, 0);
          outstanding = 1'b1;
          check("sb_nonempty", {31'b0, exp_q.size() > 0}, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("resp", {24'b0, host.resp}, {24'b0, e.b});
            if (e.a >= 0) check("byte_raddr", {23'b0, raddr}, e.a);
          end
        end
      end
    end
  end

  task automatic check_regs(input logic [5:0] trig, input logic [NUM_CH*5-1:0] chv,
                            input logic [7:0] vih_v);
    check("TrigCfg", {26'b0, TrigCfg}, {26'b0, trig});
    check("ChTrigCfg", {7'b0, ChTrigCfg}, {7'b0, chv});
    check("decimator", {28'b0, decimator}, 0);
    check("VIH", {24'b0, VIH}, {24'b0, vih_v});
    check("VIL", {24'b0, VIL}, 32'h55);
    check("matchH", {24'b0, matchH}, 0);
    check("matchL", {24'b0, matchL}, 0);
    check("maskH", {24'b0, maskH}, 0);
    check("maskL", {24'b0, maskL}, 0);
    check("baud_cntH", {24'b0, baud_cntH}, 32'h06);
    check("baud_cntL", {24'b0, baud_cntL}, 32'hC8);
    check("trig_posH", {24'b0, trig_posH}, 0);
    check("trig_posL", {24'b0, trig_posL}, 32'h01);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d,
                        input logic scd, input int lat, input int first_raddr);
    int n;
    @(negedge clk);
    host.cmd = {op, a, d};
    host.cmd_rdy = 1'b1;
    set_capture_done = scd;
    @(posedge clk);
    #1 set_capture_done = 1'b0;
    @(negedge clk);
    if (lat == 3) begin
      check("dump_first_raddr", {23'b0, raddr}, first_raddr);
      repeat (2) @(negedge clk);
    end
    check("send_latency", {31'b0, host.send_resp}, 1);
    n = 0;
    while (!host.clr_cmd_rdy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("clr_seen", {31'b0, host.clr_cmd_rdy}, 1);
    check("clr_after_resp_sent", cyc - last_rs_cyc, 1);
    host.cmd_rdy = 1'b0;
    @(negedge clk);
    check("clr_one_cycle", {31'b0, host.clr_cmd_rdy}, 0);
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic rd(input logic [5:0] a, input logic [7:0] v);
    push(v, -1);
    do_cmd(2'b00, a, 8'h00, 1'b0, 1, 0);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d, input logic [7:0] v, input logic scd);
    push(v, -1);
    do_cmd(2'b01, a, d, scd, 1, 0);
  endtask

  task automatic dump(input int ch, input int wa);
    int start, base;
    waddr = LOG2'(wa);
    start = (wa + 1) % ENTRIES;
    for (int i = 0; i < ENTRIES; i++) push(ram_byte(ch, (start + i) % ENTRIES), (start + i) % ENTRIES);
    base = n_send;
    do_cmd(2'b10, 6'(ch), 8'h00, 1'b0, 3, start);
    check("dump_count", n_send - base, ENTRIES);
  endtask

  initial begin
    int base, n;
    host.cmd = '0;
    host.cmd_rdy = 1'b0;
    set_capture_done = 1'b0;
    waddr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_resp", {24'b0, host.resp}, 0);
    check("rst_send", {31'b0, host.send_resp}, 0);
    check("rst_clr", {31'b0, host.clr_cmd_rdy}, 0);
    check("rst_raddr", {23'b0, raddr}, 0);
    check_regs(6'h03, {NUM_CH{5'h01}}, 8'hAA);

    rd(6'h17, 8'h06);
    rd(6'h18, 8'hC8);
    push(NAK, -1);
    do_cmd(2'b10, 6'h03, 8'h00, 1'b0, 1, 0);

    wr(6'h11, 8'h80, ACK, 1'b0);
    rd(6'h11, 8'h80);
    wr(6'h1F, 8'h55, NAK, 1'b0);
    check_regs(6'h03, {NUM_CH{5'h01}}, 8'h80);
    rd(6'h06, NAK);
    push(NAK, -1);
    do_cmd(2'b11, 6'h00, 8'h00, 1'b0, 1, 0);
    wr(6'h03, 8'hFF, ACK, 1'b0);
    rd(6'h03, 8'h1F);
    check("ch3_packed", {7'b0, ChTrigCfg}, {7'b0, 5'h01, 5'h01, 5'h1F, 5'h01, 5'h01});
    rd(6'h10, 8'h00);

    wr(6'h00, 8'h01, ACK, 1'b1);
    check("trig_capture_merge", {26'b0, TrigCfg}, 32'h21);
    rd(6'h00, 8'h21);

    dump(3, 383);
    dump(5, 10);
    push(NAK, -1);
    do_cmd(2'b10, 6'h06, 8'h00, 1'b0, 1, 0);
    push(NAK, -1);
    do_cmd(2'b10, 6'h00, 8'h00, 1'b0, 1, 0);

    // Reset in the middle of a dump, right after the 100th byte goes out.
    waddr = LOG2'(383);
    for (int i = 0; i < 100; i++) push(ram_byte(2, i), i);
    @(negedge clk);
    host.cmd = {2'b10, 6'h02, 8'h00};
    host.cmd_rdy = 1'b1;
    base = n_send;
    n = 0;
    while ((n_send - base) < 100 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("reached_byte_100", n_send - base, 100);
    rst = 1'b1;
    host.cmd_rdy = 1'b0;
    @(negedge clk);
    check("midrst_resp", {24'b0, host.resp}, 0);
    check("midrst_send", {31'b0, host.send_resp}, 0);
    check("midrst_clr", {31'b0, host.clr_cmd_rdy}, 0);
    check("midrst_raddr", {23'b0, raddr}, 0);
    check_regs(6'h03, {NUM_CH{5'h01}}, 8'hAA);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (host.clr_cmd_rdy) n++;
    end
    check("midrst_no_clr", n, 0);
    check("midrst_sb_drained", exp_q.size(), 0);
    rd(6'h00, 8'h03);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
